// File: rtl/uart_frame_scheduler_if.sv
// Requester/transmitter bundle for uart_frame_scheduler: request side (valid/data/ack)
// and the registered transmitter side (full_bus/tx_start) plus status.
interface uart_frame_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*65-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic [64:0]           full_bus;
    logic                  tx_start;
    logic                  busy;
    logic [2:0]            grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ack, full_bus, tx_start, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ack, full_bus, tx_start, busy, grant_id
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Time-shares one 65-bit UART frame transmitter among NUM_REQ requesters, holding the bus
// for a full frame. Define UART_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration.
module uart_frame_scheduler #(
    parameter int NUM_REQ      = 2,
    parameter int FRAME_CYCLES = 520830,
    parameter int TIMER_W      = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_frame_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        S_HOLDOFF = 2'd0,
        S_IDLE    = 2'd1,
        S_START   = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    state_t               r_state;
    logic [TIMER_W-1:0]   r_timer;
    logic [2:0]           r_rr_ptr;
    logic [2:0]           r_grant_id;
    logic [NUM_REQ-1:0]   r_ack;
    logic [64:0]          r_full_bus;
    logic                 r_tx_start;
    logic                 r_busy;

    logic [64:0]          w_word [0:7];
    logic                 w_any;
    logic [2:0]           w_pos;
    logic [2:0]           w_winner;
    logic [NUM_REQ-1:0]   w_sel_vec;

    // Unused slots read as zero so the 3-bit winner index always lands in range.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_word
            if (gi < NUM_REQ) begin : g_used
                assign w_word[gi] = bus.req_data[gi*65 +: 65];
            end else begin : g_unused
                assign w_word[gi] = '0;
            end
        end
    endgenerate

    assign w_any = |bus.req_valid;

`ifdef UART_SCHED_FIXED_PRIO_EN
    assign w_sel_vec = bus.req_valid;
    assign w_winner  = w_pos;
`else
    logic [2*NUM_REQ-1:0] w_valid_dbl;
    logic [3:0]           w_shamt;
    logic [3:0]           w_sum;

    // Rotate so bit 0 is the requester after the last winner; shifting by NUM_REQ wraps to 0.
    assign w_valid_dbl = {bus.req_valid, bus.req_valid};
    assign w_shamt     = {1'b0, r_rr_ptr} + 4'd1;
    assign w_sel_vec   = NUM_REQ'(w_valid_dbl >> w_shamt);
    assign w_sum       = w_shamt + {1'b0, w_pos};
    assign w_winner    = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : w_sum[2:0];
`endif

    always_comb begin
        w_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel_vec[i]) w_pos = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HOLDOFF;
            r_timer    <= TIMER_W'(FRAME_CYCLES - 1);
            r_rr_ptr   <= 3'(NUM_REQ - 1);
            r_grant_id <= 3'(NUM_REQ - 1);
            r_ack      <= '0;
            r_full_bus <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_HOLDOFF, S_WAIT: begin
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_full_bus <= w_word[w_winner];
                        r_ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_state    <= S_START;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b1;
                    r_timer    <= TIMER_W'(FRAME_CYCLES - 1);
                    r_state    <= S_WAIT;
                end
                default: r_state <= S_HOLDOFF;
            endcase
        end
    end

    assign bus.req_ack  = r_ack;
    assign bus.full_bus = r_full_bus;
    assign bus.tx_start = r_tx_start;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_grant_id;
endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Randomized bench for uart_frame_scheduler against a grant-time reference model
// (earliest legal grant cycle + arbitration rule), checking every output each clock.
module tb_uart_frame_scheduler;
    localparam int N  = 2;
    localparam int FC = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_frame_scheduler_if #(.NUM_REQ(N)) bus_if ();

    uart_frame_scheduler #(
        .NUM_REQ(N), .FRAME_CYCLES(FC), .TIMER_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          cyc = 0;
    int          earliest = 0;
    int          m_rr = N - 1;
    int          m_gid = N - 1;
    logic [64:0] m_bus = '0;
    logic [N-1:0] m_ack = '0;
    bit          m_tx = 1'b0;
    bit          m_busy = 1'b1;
    bit          grant_prev = 1'b0;

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0]     v;
        logic [N*65-1:0]  d;
        logic             r;
        bit               g;
        int               w;
        @(posedge clk);
        v = bus_if.req_valid;
        d = bus_if.req_data;
        r = rst;
        if (r) begin
            earliest   = cyc + FC + 1;
            m_rr       = N - 1;
            m_gid      = N - 1;
            m_bus      = '0;
            m_ack      = '0;
            m_tx       = 1'b0;
            m_busy     = 1'b1;
            grant_prev = 1'b0;
        end else begin
            m_tx   = grant_prev;
            g      = (cyc >= earliest) && (v != '0);
            m_busy = g || (cyc < earliest - 1);
            m_ack  = '0;
            if (g) begin
                w = -1;
`ifdef UART_SCHED_FIXED_PRIO_EN
                for (int i = 0; i < N; i++)
                    if (w < 0 && v[i]) w = i;
`else
                for (int off = 1; off <= N; off++)
                    if (w < 0 && v[(m_rr + off) % N]) w = (m_rr + off) % N;
`endif
                m_rr     = w;
                m_gid    = w;
                m_bus    = d[w*65 +: 65];
                m_ack[w] = 1'b1;
                earliest = cyc + FC + 2;
                $display("grant cyc=%0d id=%0d data=%h", cyc, w, m_bus);
            end
            grant_prev = g;
        end
        cyc++;
        #1;
        check_val("req_ack",  65'(bus_if.req_ack), 65'(m_ack));
        check_val("full_bus", bus_if.full_bus, m_bus);
        check_val("tx_start", 65'(bus_if.tx_start), 65'(m_tx));
        check_val("busy",     65'(bus_if.busy), 65'(m_busy));
        check_val("grant_id", 65'(bus_if.grant_id), 65'(m_gid));
    endtask

    function automatic logic [64:0] rand_word();
        return {1'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic wait_tx(input string tag);
        for (int i = 0; i < 3 * FC && !bus_if.tx_start; i++) step();
        check_val(tag, 65'(bus_if.tx_start), 65'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        repeat (3) step();
        rst = 1'b0;

        // Single requester through holdoff, then one frame
        bus_if.req_valid = 2'b01;
        bus_if.req_data[64:0] = 65'h1_DEAD_BEEF_CAFE_F00D;
        bus_if.req_data[129:65] = rand_word();
        repeat (FC + 30) step();

        // Both continuously valid: alternating grants at minimum spacing
        bus_if.req_valid = 2'b11;
        repeat (5 * (FC + 2)) step();

        // Late request and data change during WAIT
        bus_if.req_valid = 2'b01;
        wait_tx("tx_wait_a");
        repeat (4) step();
        bus_if.req_valid = 2'b11;
        bus_if.req_data[64:0] = rand_word();
        repeat (FC + 5) step();

        // Reset mid-WAIT
        wait_tx("tx_wait_b");
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (FC + 10) step();

        // One-cycle pulse during WAIT, dropped before IDLE
        bus_if.req_valid = 2'b01;
        wait_tx("tx_wait_c");
        bus_if.req_valid = 2'b00;
        repeat (3) step();
        bus_if.req_valid = 2'b01;
        step();
        bus_if.req_valid = 2'b00;
        repeat (FC + 15) step();

        // Randomized traffic with persistent valids and occasional resets
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(9, 0) == 0) bus_if.req_valid[i] = ~bus_if.req_valid[i];
                if ($urandom_range(7, 0) == 0) bus_if.req_data[i*65 +: 65] = rand_word();
            end
            rst = ($urandom_range(299, 0) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
